// File: rtl/dram_axi_burst_writer.sv
// Drains the command and data FIFOs into AXI4 INCR write bursts, one burst in
// flight at a time, splitting any command that would cross a 4 KB boundary.
module dram_axi_burst_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_LEN   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] ctrl_dout,
    input  logic        ctrl_empty,
    output logic        ctrl_re,
    input  logic [35:0] data_dout,
    input  logic        data_empty,
    output logic        data_re,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic        err_clr,
    output logic        busy,
    output logic        resp_err,
    output logic        len_err,
    output logic [31:0] burst_cnt
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        cmd_pend_q, cmd_pend_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [8:0]  cmd_len_q, cmd_len_d;
    logic [8:0]  cur_len_q, cur_len_d;
    logic [8:0]  rem_len_q, rem_len_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic        resp_err_q, resp_err_d;
    logic        len_err_q, len_err_d;

    logic [12:0] room;
    logic [8:0]  awlen_full;
    logic        len_bad;
    logic        len_set;
    logic        resp_set;

    // Words left before the next 4 KB boundary: 1..1024.
    assign room    = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> 2;
    assign len_bad = (cmd_len_q == 9'd0) || ({23'd0, cmd_len_q} > MAX_LEN);
    assign awlen_full = cur_len_q - 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_pend_q  <= 1'b0;
            cur_addr_q  <= 32'd0;
            cmd_len_q   <= 9'd0;
            cur_len_q   <= 9'd0;
            rem_len_q   <= 9'd0;
            beat_cnt_q  <= 9'd0;
            burst_cnt_q <= 32'd0;
            resp_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_pend_q  <= cmd_pend_d;
            cur_addr_q  <= cur_addr_d;
            cmd_len_q   <= cmd_len_d;
            cur_len_q   <= cur_len_d;
            rem_len_q   <= rem_len_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            resp_err_q  <= resp_err_d;
            len_err_q   <= len_err_d;
        end
    end

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high; awvalid and its payload stay put until accepted, wvalid simply
    // follows data availability, and FIFO pops happen only on a transfer.
    always_comb begin
        state_d       = state_q;
        cmd_pend_d    = cmd_pend_q;
        cur_addr_d    = cur_addr_q;
        cmd_len_d     = cmd_len_q;
        cur_len_d     = cur_len_q;
        rem_len_d     = rem_len_q;
        beat_cnt_d    = beat_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        len_set       = 1'b0;
        resp_set      = 1'b0;
        ctrl_re       = 1'b0;
        data_re       = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_pend_q) begin
                    cmd_pend_d = 1'b0;
                    if (len_bad) begin
                        len_set = 1'b1;
                    end else begin
                        if ({4'd0, cmd_len_q} > room) begin
                            cur_len_d = room[8:0];
                            rem_len_d = cmd_len_q - room[8:0];
                        end else begin
                            cur_len_d = cmd_len_q;
                            rem_len_d = 9'd0;
                        end
                        state_d = ADDR;
                    end
                end else if (!ctrl_empty && !rst) begin
                    ctrl_re    = 1'b1;
                    cmd_pend_d = 1'b1;
                    cur_addr_d = (ctrl_dout[31:0] + BASE_ADDR) & 32'hFFFF_FFFC;
                    cmd_len_d  = {1'b0, ctrl_dout[39:32]};
                end
            end
            ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d    = DATA;
                    beat_cnt_d = 9'd0;
                end
            end
            DATA: begin
                m_axi_wvalid = !data_empty;
                m_axi_wlast  = m_axi_wvalid && (beat_cnt_q == awlen_full);
                if (m_axi_wvalid && m_axi_wready) begin
                    data_re    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (m_axi_wlast) state_d = RESP;
                end
            end
            RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    resp_set    = (m_axi_bresp != 2'b00);
                    if (rem_len_q != 9'd0) begin
                        cur_addr_d = cur_addr_q + {21'd0, cur_len_q, 2'b00};
                        cur_len_d  = rem_len_q;
                        rem_len_d  = 9'd0;
                        state_d    = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Sticky flags: a new error in the clearing cycle is kept.
        len_err_d  = len_set  ? 1'b1 : (err_clr ? 1'b0 : len_err_q);
        resp_err_d = resp_set ? 1'b1 : (err_clr ? 1'b0 : resp_err_q);
    end

    assign m_axi_awaddr  = m_axi_awvalid ? cur_addr_q : 32'd0;
    assign m_axi_awlen   = m_axi_awvalid ? awlen_full[7:0] : 8'd0;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = m_axi_wvalid ? data_dout[31:0] : 32'd0;
    assign m_axi_wstrb   = m_axi_wvalid ? data_dout[35:32] : 4'd0;
    assign busy          = (state_q != IDLE);
    assign resp_err      = resp_err_q;
    assign len_err       = len_err_q;
    assign burst_cnt     = burst_cnt_q;

endmodule

// File: tb/tb_dram_axi_burst_writer.sv
// Bench for dram_axi_burst_writer: FIFO and AXI slave models, a table of
// hand-computed bursts, corner-case sequences and randomized commands.
module tb_dram_axi_burst_writer;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXL = 256;

    logic        clk, rst;
    logic [39:0] ctrl_dout;
    logic        ctrl_empty, ctrl_re;
    logic [35:0] data_dout;
    logic        data_empty, data_re;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        err_clr, busy, resp_err, len_err;
    logic [31:0] burst_cnt;

    dram_axi_burst_writer #(.BASE_ADDR(BASE), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst),
        .ctrl_dout(ctrl_dout), .ctrl_empty(ctrl_empty), .ctrl_re(ctrl_re),
        .data_dout(data_dout), .data_empty(data_empty), .data_re(data_re),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .err_clr(err_clr), .busy(busy), .resp_err(resp_err),
        .len_err(len_err), .burst_cnt(burst_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment state
    logic [39:0] ctrl_fifo[$];
    logic [35:0] data_fifo[$];
    logic [39:0] exp_aw[$];
    logic [39:0] got_aw[$];
    logic [36:0] exp_w[$];
    logic [36:0] got_w[$];
    int          total, bad, proto_err, exp_bcnt;
    bit          exp_len_err, exp_resp_err;
    int unsigned aw_pct, w_pct, b_pct, stall_pct;
    logic [1:0]  bresp_val;
    bit          aw_hold;
    logic [39:0] aw_prev;

    typedef struct {
        int          len;
        logic [31:0] addr;
        int          nb;
        logic [31:0] a0;
        int          l0;
        logic [31:0] a1;
        int          l1;
        bit          lerr;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // FIFO and AXI slave driver plus handshake monitor
    initial begin
        forever begin
            @(negedge clk);
            ctrl_empty    = (ctrl_fifo.size() == 0);
            ctrl_dout     = ctrl_empty ? 40'd0 : ctrl_fifo[0];
            data_empty    = (data_fifo.size() == 0) || ($urandom_range(99) < stall_pct);
            data_dout     = (data_fifo.size() == 0) ? 36'd0 : data_fifo[0];
            m_axi_awready = ($urandom_range(99) < aw_pct);
            m_axi_wready  = ($urandom_range(99) < w_pct);
            m_axi_bvalid  = ($urandom_range(99) < b_pct);
            m_axi_bresp   = bresp_val;
            #1;
            if (!rst) begin
                if (ctrl_re) begin
                    if (ctrl_empty) proto_err++;
                    else void'(ctrl_fifo.pop_front());
                end
                if (data_re) begin
                    if (data_empty || !(m_axi_wvalid && m_axi_wready)) proto_err++;
                    else void'(data_fifo.pop_front());
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    got_w.push_back({m_axi_wlast, m_axi_wstrb, m_axi_wdata});
                    if (!data_re) proto_err++;
                end
                if (aw_hold && (!m_axi_awvalid || {m_axi_awlen, m_axi_awaddr} != aw_prev))
                    proto_err++;
                if (m_axi_awvalid && m_axi_awready)
                    got_aw.push_back({m_axi_awlen, m_axi_awaddr});
                aw_hold = m_axi_awvalid && !m_axi_awready;
                aw_prev = {m_axi_awlen, m_axi_awaddr};
            end else begin
                aw_hold = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic push_cmd(input int len, input logic [31:0] addr, input int first);
        logic [35:0] w;
        logic        lst;
        if (first > 0) begin
            for (int i = 0; i < len; i++) begin
                w = {4'($urandom_range(15)), 32'($urandom)};
                lst = (i == first - 1) || (i == len - 1);
                data_fifo.push_back(w);
                exp_w.push_back({lst, w});
            end
        end
        ctrl_fifo.push_back({8'(len), addr});
    endtask

    // Reference model: bursts derived from the byte range of the command
    task automatic model_cmd(input int len, input logic [31:0] addr);
        logic [31:0] start;
        int          edge_w, first;
        start = (addr + BASE) & 32'hFFFF_FFFC;
        if (len == 0 || len > MAXL) begin
            exp_len_err = 1'b1;
            push_cmd(len, addr, 0);
            return;
        end
        edge_w = int'((32'd4096 - (start % 32'd4096)) / 32'd4);
        first  = (len < edge_w) ? len : edge_w;
        exp_aw.push_back({8'(first - 1), start});
        exp_bcnt++;
        if (len > first) begin
            exp_aw.push_back({8'(len - first - 1), start + 32'(first * 4)});
            exp_bcnt++;
        end
        push_cmd(len, addr, first);
    endtask

    task automatic wait_done(input int budget);
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
            if (ctrl_fifo.size() == 0 && !busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            total++;
            bad++;
            $display("FAIL drain_timeout waited=%0d cycles limit=%0d", n, budget);
        end
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_len_err  = 1'b0;
        exp_resp_err = 1'b0;
    endtask

    // Scoreboard
    task automatic score(input string name);
        check({name, " aw_count"}, 64'(got_aw.size()), 64'(exp_aw.size()));
        for (int k = 0; k < exp_aw.size() && k < got_aw.size(); k++)
            check($sformatf("%s aw%0d {len,addr}", name, k), 64'(got_aw[k]), 64'(exp_aw[k]));
        check({name, " beat_count"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++)
            check($sformatf("%s beat%0d {last,strb,data}", name, k), 64'(got_w[k]), 64'(exp_w[k]));
        check({name, " burst_cnt"}, 64'(burst_cnt), 64'(exp_bcnt));
        check({name, " len_err"}, 64'(len_err), 64'(exp_len_err));
        check({name, " resp_err"}, 64'(resp_err), 64'(exp_resp_err));
        check({name, " protocol_errors"}, 64'(proto_err), 64'd0);
        check({name, " data_left"}, 64'(data_fifo.size()), 64'd0);
        got_aw.delete();
        exp_aw.delete();
        got_w.delete();
        exp_w.delete();
    endtask

    initial begin
        int n;
        int len;
        logic [31:0] addr;

        total = 0; bad = 0; proto_err = 0; exp_bcnt = 0;
        exp_len_err = 1'b0; exp_resp_err = 1'b0;
        aw_pct = 100; w_pct = 100; b_pct = 100; stall_pct = 0;
        bresp_val = 2'b00; aw_hold = 1'b0; aw_prev = 40'd0;
        rst = 1'b1; err_clr = 1'b0;
        ctrl_empty = 1'b1; ctrl_dout = 40'd0; data_empty = 1'b1; data_dout = 36'd0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;

        vt[0] = '{64,  32'h0000_0100, 1, 32'h0000_0100, 64,  32'h0,         0, 1'b0};
        vt[1] = '{64,  32'h0000_0FC0, 2, 32'h0000_0FC0, 16,  32'h0000_1000, 48, 1'b0};
        vt[2] = '{5,   32'h0000_0200, 1, 32'h0000_0200, 5,   32'h0,         0, 1'b0};
        vt[3] = '{1,   32'h0000_0FFC, 1, 32'h0000_0FFC, 1,   32'h0,         0, 1'b0};
        vt[4] = '{2,   32'h0000_0FFC, 2, 32'h0000_0FFC, 1,   32'h0000_1000, 1, 1'b0};
        vt[5] = '{255, 32'h0000_1003, 1, 32'h0000_1000, 255, 32'h0,         0, 1'b0};
        vt[6] = '{8,   32'hFFFF_FFF8, 2, 32'hFFFF_FFF8, 2,   32'h0000_0000, 6, 1'b0};
        vt[7] = '{0,   32'h0000_0200, 0, 32'h0,         0,   32'h0,         0, 1'b1};

        // Reset state
        #12;
        check("reset awvalid", 64'(m_axi_awvalid), 64'd0);
        check("reset wvalid", 64'(m_axi_wvalid), 64'd0);
        check("reset bready", 64'(m_axi_bready), 64'd0);
        check("reset ctrl_re", 64'(ctrl_re), 64'd0);
        check("reset awsize", 64'(m_axi_awsize), 64'd2);
        check("reset awburst", 64'(m_axi_awburst), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset burst_cnt", 64'(burst_cnt), 64'd0);
        check("reset flags", 64'({len_err, resp_err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of hand-computed bursts
        for (int i = 0; i < 8; i++) begin
            if (vt[i].nb > 0) exp_aw.push_back({8'(vt[i].l0 - 1), vt[i].a0});
            if (vt[i].nb > 1) exp_aw.push_back({8'(vt[i].l1 - 1), vt[i].a1});
            push_cmd(vt[i].len, vt[i].addr, (vt[i].nb > 0) ? vt[i].l0 : 0);
            exp_bcnt += vt[i].nb;
            exp_len_err = vt[i].lerr;
            wait_done(3000);
            score($sformatf("vec%0d", i));
            pulse_err_clr();
        end

        // Backpressure on every channel with data gaps
        aw_pct = 40; w_pct = 50; b_pct = 30; stall_pct = 30;
        model_cmd(20, 32'h0000_3000);
        wait_done(5000);
        score("backpressure");

        // Dropped command followed by a good one, then clear
        model_cmd(0, 32'h0000_0200);
        model_cmd(5, 32'h0000_0200);
        wait_done(3000);
        score("drop");
        pulse_err_clr();
        #2;
        check("drop len_err cleared", 64'(len_err), 64'd0);

        // Error response is sticky until cleared
        aw_pct = 100; w_pct = 100; b_pct = 100; stall_pct = 0;
        bresp_val = 2'b10;
        model_cmd(8, 32'h0000_0600);
        exp_resp_err = 1'b1;
        wait_done(3000);
        score("slverr");
        bresp_val = 2'b00;
        model_cmd(3, 32'h0000_0700);
        wait_done(3000);
        score("after_slverr");
        pulse_err_clr();
        #2;
        check("resp_err cleared", 64'(resp_err), 64'd0);

        // Randomized commands against the model
        aw_pct = 60; w_pct = 60; b_pct = 40; stall_pct = 25;
        for (int r = 0; r < 12; r++) begin
            len  = $urandom_range(40, 1);
            if ($urandom_range(7) == 0) len = 0;
            addr = $urandom;
            if ($urandom_range(1) == 1) addr = {addr[31:12], 4'hF, addr[7:0]};
            model_cmd(len, addr);
        end
        wait_done(20000);
        score("random");
        pulse_err_clr();

        // Reset in the middle of a data burst
        aw_pct = 100; w_pct = 100; b_pct = 100; stall_pct = 0;
        exp_aw.push_back({8'd31, 32'h0000_0400});
        push_cmd(32, 32'h0000_0400, 32);
        n = 0;
        while (got_w.size() < 10 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("midrst reached beat 10", 64'(got_w.size() >= 10), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst beats done", 64'(got_w.size()), 64'd10);
        check("midrst awvalid", 64'(m_axi_awvalid), 64'd0);
        check("midrst wvalid", 64'(m_axi_wvalid), 64'd0);
        check("midrst wlast", 64'(m_axi_wlast), 64'd0);
        check("midrst wdata", 64'(m_axi_wdata), 64'd0);
        check("midrst data_re", 64'(data_re), 64'd0);
        check("midrst bready", 64'(m_axi_bready), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst burst_cnt", 64'(burst_cnt), 64'd0);
        ctrl_fifo.delete();
        data_fifo.delete();
        got_aw.delete(); exp_aw.delete(); got_w.delete(); exp_w.delete();
        exp_bcnt = 0; exp_len_err = 1'b0; exp_resp_err = 1'b0;
        model_cmd(4, 32'h0000_0800);
        repeat (2) @(negedge clk);
        #2;
        check("reset holds ctrl_re low", 64'(ctrl_re), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(3000);
        score("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_axi_burst_writer.md
Name: dram_axi_burst_writer

Overview:
- Downstream stage of the video capture-to-DRAM path. Drains the DRAM-write data FIFO and command FIFO and issues AXI4 INCR write bursts to the memory controller.
- Data FIFO entries are {strb[35:32], data[31:0]}. Command FIFO entries are {len[39:32], addr[31:0]}.
- A command whose burst would cross a 4 KB boundary is split into two legal AXI bursts.
- One outstanding burst at a time; this is a simple, deterministic ordering.

Parameters:
- BASE_ADDR, 32'h0000_0000, added to every command address before issue (frame buffer base).
- MAX_LEN, 256, largest accepted command length in words. Commands with len > MAX_LEN are dropped and flagged.

Ports:
- clk  in  1  system/DRAM-side clock; all logic is on this clock.
- rst  in  1  asynchronous, active-high reset.
- ctrl_dout  in  40  command FIFO head {len, addr}; first-word-fall-through.
- ctrl_empty  in  1  command FIFO empty.
- ctrl_re  out  1  pops the command FIFO; one-cycle pulse.
- data_dout  in  36  data FIFO head {strb, data}; first-word-fall-through.
- data_empty  in  1  data FIFO empty.
- data_re  out  1  pops the data FIFO.
- m_axi_awaddr  out  32  burst start byte address.
- m_axi_awlen  out  8  beats minus 1.
- m_axi_awsize  out  3  constant 3'b010 (4 bytes).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  32; m_axi_wstrb  out  4; m_axi_wlast  out  1.
- m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- err_clr  in  1  clears the sticky error flags.
- busy  out  1  high whenever state != IDLE.
- resp_err  out  1  sticky: a bresp != 2'b00 was received.
- len_err  out  1  sticky: a command with len==0 or len>MAX_LEN was dropped.
- burst_cnt  out  32  count of completed AXI bursts (B handshakes); wraps at 2^32.

Behaviour:
- Reset: all outputs are 0 except the constants awsize/awburst. State is IDLE. All counters and sticky flags are 0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If !ctrl_empty, pulse ctrl_re for one cycle and latch the command: cmd_addr = (addr + BASE_ADDR) with bits [1:0] forced to 0, and cmd_len = len.
  - If len==0 or len>MAX_LEN: set len_err and stay in IDLE. No AXI activity and no data popped.
  - Otherwise compute the split:
    - room = (4096 - cmd_addr[11:0]) >> 2, in words.
    - If cmd_len > room: cur_len = room, rem_len = cmd_len - room.
    - Else: cur_len = cmd_len, rem_len = 0.
  - Go to ADDR on the next cycle. Latency from ctrl_empty falling to awvalid rising is 2 cycles.
- ADDR:
  - awvalid=1, awaddr=cur_addr, awlen=cur_len-1.
  - These are held stable until awready. On awvalid&&awready go to DATA and clear beat_cnt.
- DATA:
  - wvalid = !data_empty. wdata/wstrb come combinationally from data_dout.
  - wlast = (beat_cnt == cur_len-1) while wvalid.
  - data_re = wvalid && wready. beat_cnt increments on each W handshake.
  - An empty data FIFO mid-burst only stalls wvalid. There is no timeout.
  - On the handshake with wlast go to RESP.
- RESP:
  - bready=1. On bvalid: burst_cnt += 1, and if bresp != 0 set resp_err.
  - If rem_len != 0: cur_addr = cur_addr + cur_len*4 (lands on the 4 KB boundary), cur_len = rem_len, rem_len = 0, go to ADDR.
  - Otherwise go to IDLE.
- A second command is never popped before the B response of the previous command.
- Address arithmetic is 32-bit and wraps modulo 2^32. The length math is 9-bit internally so that 256 fits.
- err_clr clears both sticky flags. If a set event occurs in the same cycle as err_clr, the set wins.
- Reset asserted mid-burst aborts immediately: all valids drop asynchronously and no FIFO pops occur. Recovering the AXI slave and the FIFOs is the system's responsibility.
- ctrl_re and data_re never assert while the respective empty flag is high.

Test Plan:
- Single command {64, 0x0000_0100}, 64 data words present, awready/wready/bvalid tied high:
  - awaddr=0x100, awlen=63, exactly 64 W beats.
  - wlast only on beat 64; burst_cnt=1; busy returns low.
- 4 KB split: command {64, 0x0000_0FC0}, BASE_ADDR=0:
  - Burst 1: awaddr=0xFC0, awlen=15.
  - Burst 2: awaddr=0x1000, awlen=47.
  - 64 data pops in total; burst_cnt=2.
- Backpressure: random awready/wready/bvalid and data_empty toggling during a len=20 command:
  - AW/W signals held stable while not accepted.
  - No pop occurs without a handshake; exactly 20 beats; data order preserved.
- Drop: command {0, 0x200} then {5, 0x200}:
  - len_err=1 and the first command produces no AXI traffic.
  - The second command produces a 5-beat burst.
  - err_clr then clears len_err.
- Error response: bresp=2'b10 on a len=8 burst:
  - resp_err=1 and stays set until err_clr.
  - The next command still executes normally.
- Reset mid-DATA after 10 of 32 beats:
  - All outputs go to 0 immediately.
  - After release, a new command starts cleanly from IDLE with burst_cnt=0.
